pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Brings a PLLE2_BASE out of reset with lock timeout/retry,
//                lock-stability qualification and a downstream system reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT       = 4096,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retries,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [15:0] C_HOLD_LAST    = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] C_STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] C_CNT_MAX      = 16'hFFFF;
  localparam logic [3:0]  C_MAX_RETRIES  = 4'(MAX_RETRIES);

  logic [1:0]  r_sync;
  logic        w_locked_s;
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [3:0]  r_retries;
  logic [3:0]  w_retries_next;
  logic        r_lock_lost;
  logic        w_lock_lost_next;
  logic        w_hold_done;
  logic        w_timeout;
  logic        w_stable_done;

  logic        r_pll_rst;
  logic        r_pll_pwrdwn;
  logic        r_sys_reset;
  logic        r_ready;
  logic        r_fail;
  logic        w_pll_rst;
  logic        w_pll_pwrdwn;
  logic        w_sys_reset;
  logic        w_ready;
  logic        w_fail;

  // pll_locked is asynchronous to clk; only the second flop is ever used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
    end
  end

  assign w_locked_s    = r_sync[1];
  assign w_hold_done   = (r_cnt == C_HOLD_LAST);
  assign w_timeout     = (r_cnt == C_TIMEOUT_LAST);
  assign w_stable_done = (r_cnt == C_STABLE_LAST);

  always_comb begin
    w_state_next     = r_state;
    w_retries_next   = r_retries;
    w_lock_lost_next = r_lock_lost;
    if (!enable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next     = S_HOLD;
          w_retries_next   = 4'd0;
          w_lock_lost_next = 1'b0;
        end
        S_HOLD: begin
          if (w_hold_done) begin
            w_state_next = S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle still counts as a lock.
          if (w_locked_s) begin
            w_state_next = S_STABLE;
          end else if (w_timeout) begin
            if (r_retries < C_MAX_RETRIES) begin
              w_state_next   = S_HOLD;
              w_retries_next = r_retries + 4'd1;
            end else begin
              w_state_next = S_FAIL;
            end
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_state_next = S_WAIT_LOCK;
          end else if (w_stable_done) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_state_next     = S_HOLD;
            w_lock_lost_next = 1'b1;
            w_retries_next   = 4'd0;
          end
        end
        S_FAIL: begin
          w_state_next = S_FAIL;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_pll_rst    = 1'b1;
    w_pll_pwrdwn = 1'b0;
    w_sys_reset  = 1'b1;
    w_ready      = 1'b0;
    w_fail       = 1'b0;
    case (w_state_next)
      S_IDLE: begin
        w_pll_pwrdwn = 1'b1;
      end
      S_HOLD: begin
        w_pll_rst = 1'b1;
      end
      S_WAIT_LOCK, S_STABLE: begin
        w_pll_rst = 1'b0;
      end
      S_RUN: begin
        w_pll_rst   = 1'b0;
        w_sys_reset = 1'b0;
        w_ready     = 1'b1;
      end
      S_FAIL: begin
        w_fail = 1'b1;
      end
      default: begin
        w_pll_pwrdwn = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_retries   <= 4'd0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_retries   <= w_retries_next;
      r_lock_lost <= w_lock_lost_next;
      if (w_state_next != r_state) begin
        r_cnt <= 16'd0;
      end else if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pll_rst    <= 1'b1;
      r_pll_pwrdwn <= 1'b1;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_pll_rst    <= w_pll_rst;
      r_pll_pwrdwn <= w_pll_pwrdwn;
      r_sys_reset  <= w_sys_reset;
      r_ready      <= w_ready;
      r_fail       <= w_fail;
    end
  end

  assign pll_rst    = r_pll_rst;
  assign pll_pwrdwn = r_pll_pwrdwn;
  assign sys_reset  = r_sys_reset;
  assign ready      = r_ready;
  assign fail       = r_fail;
  assign lock_lost  = r_lock_lost;
  assign retries    = r_retries;
  assign state      = r_state;

endmodule
`default_nettype wire
